axis_frame_arbiter: RTL and testbench

Frame-level round-robin arbiter that shares one AXI-Stream output among NUM_SRC AXI-Stream sources. It sits between several stream producers and a single AXI_stream_master/slave link. Once granted, a source owns the output until its tlast beat is accepted, so frames are never interleaved.

---
 rtl/axis_arb_pkg.sv | 21 ++
 rtl/axis_rr_select.sv | 43 ++++
 rtl/axis_frame_arbiter.sv | 159 +++++++++++++++
 tb/tb_axis_frame_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared types and constants for the AXI-Stream frame arbiter.
//   arb_state_e : arbiter FSM states (IDLE, XFER)
//   STATS_W     : width of the optional frame/beat statistics counters
//   grant_w()   : width of a source index for a given number of sources
// -----------------------------------------------------------------------------
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int STATS_W = 16;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_rr_select.sv
// -----------------------------------------------------------------------------
// axis_rr_select
// Combinational round-robin picker. Returns the first set request bit found
// scanning upward from rr_ptr, wrapping from NUM_SRC-1 back to 0.
// Ports:
//   req     in  NUM_SRC   request vector
//   rr_ptr  in  GRANT_W   index that has highest priority this round
//   grant   out GRANT_W   selected index (0 when no request)
//   any_req out 1         at least one request bit set
// -----------------------------------------------------------------------------
module axis_rr_select
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int GRANT_W = grant_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic [GRANT_W-1:0] grant,
    output logic               any_req
);

    // One extra bit so rr_ptr + offset cannot overflow before the wrap.
    logic [GRANT_W:0] idx;

    always_comb begin
        grant   = '0;
        any_req = |req;
        idx     = '0;
        // Walk offsets from farthest to nearest so the nearest requester
        // at or above rr_ptr is the last (winning) assignment.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (GRANT_W + 1)'(k);
            if (idx >= (GRANT_W + 1)'(NUM_SRC)) begin
                idx = idx - (GRANT_W + 1)'(NUM_SRC);
            end
            if (req[idx[GRANT_W-1:0]]) begin
                grant = idx[GRANT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// axis_frame_arbiter
// Frame-level round-robin arbiter sharing one AXI-Stream output among NUM_SRC
// sources. A granted source owns the output until its tlast beat is accepted.
// Optional statistics counters are enabled with `define AXIS_ARB_STATS_EN.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/
//   tlast/tuser  in          packed per-source streams (source i in slice i)
//   s_axis_tready out        per-source ready (only granted source in XFER)
//   m_axis_tdata/tvalid/
//   tlast/tuser  out         output stream (pass-through of granted source)
//   m_axis_tready in         downstream ready
//   grant_id     out         current/last granted source
//   busy         out         high while in XFER
//   frame_cnt    out         (AXIS_ARB_STATS_EN) accepted frames, wrapping
//   beat_cnt     out         (AXIS_ARB_STATS_EN) beats of current frame, saturating
// -----------------------------------------------------------------------------
module axis_frame_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_SRC    = 4,
    localparam int GRANT_W    = grant_w(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    input  logic [NUM_SRC-1:0]            s_axis_tuser,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic                          m_axis_tready,
    output logic [GRANT_W-1:0]            grant_id,
    output logic                          busy
`ifdef AXIS_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]            frame_cnt,
    output logic [STATS_W-1:0]            beat_cnt
`endif
);

    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [GRANT_W-1:0] pick;
    logic               any_req;
    logic               beat_acc;

    axis_rr_select #(
        .NUM_SRC (NUM_SRC),
        .GRANT_W (GRANT_W)
    ) u_rr_select (
        .req     (s_axis_tvalid),
        .rr_ptr  (rr_ptr_q),
        .grant   (pick),
        .any_req (any_req)
    );

    // Output mux. Driven from registered state only, so an async reset
    // drops the output in the same cycle it asserts.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        if (state_q == XFER) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_q == GRANT_W'(i)) begin
                    m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    m_axis_tlast     = s_axis_tlast[i];
                    m_axis_tuser     = s_axis_tuser[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    assign beat_acc = m_axis_tvalid & m_axis_tready;

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (beat_acc && m_axis_tlast) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == GRANT_W'(NUM_SRC - 1)) ? '0
                                                                  : grant_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == XFER);

`ifdef AXIS_ARB_STATS_EN
    logic [STATS_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [STATS_W-1:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        if (state_q == IDLE && any_req) begin
            beat_cnt_d = '0;
        end else if (beat_acc && beat_cnt_q != '1) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (beat_acc && m_axis_tlast) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign beat_cnt  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_arbiter
// Directed bench for axis_frame_arbiter (NUM_SRC=4, DATA_WIDTH=32). Sources are
// simple frame generators that advance on their own accepted beats; expected
// output values are written out per step.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_frame_arbiter;

    localparam int DW = 32;
    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NS*DW-1:0] s_tdata;
    logic [NS-1:0]   s_tvalid;
    logic [NS-1:0]   s_tlast;
    logic [NS-1:0]   s_tuser;
    logic [NS-1:0]   s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tuser;
    logic            m_tready;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef AXIS_ARB_STATS_EN
    logic [15:0]     frame_cnt;
    logic [15:0]     beat_cnt;
`endif

    always #5 clk = ~clk;

    axis_frame_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_SRC    (NS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_tready (m_tready),
        .grant_id      (grant_id),
        .busy          (busy)
`ifdef AXIS_ARB_STATS_EN
        ,
        .frame_cnt     (frame_cnt),
        .beat_cnt      (beat_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int out_beats = 0;

    // Source frame generator state
    logic [31:0] sd[NS];
    int          slen[NS];
    int          sfr[NS];
    int          flen[NS];
    bit          sfirst[NS];
    logic [NS-1:0] hold = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            s_tvalid[i]          = (sfr[i] > 0) && !hold[i];
            s_tdata[i*DW +: DW]  = sd[i];
            s_tlast[i]           = (slen[i] == 1);
            s_tuser[i]           = sfirst[i];
        end
    endtask

    task automatic start_src(input int i, input int nfr, input int len, input logic [31:0] base);
        sfr[i]    = nfr;
        flen[i]   = len;
        slen[i]   = len;
        sd[i]     = base;
        sfirst[i] = 1'b1;
        drive();
    endtask

    task automatic kill_all();
        for (int i = 0; i < NS; i++) sfr[i] = 0;
        drive();
    endtask

    // One clock: note handshakes before the edge, advance sources after it.
    task automatic cyc();
        logic [NS-1:0] acc;
        acc = s_tvalid & s_tready;
        if (m_tvalid && m_tready) out_beats++;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (acc[i]) begin
                sd[i]     = sd[i] + 1;
                sfirst[i] = 1'b0;
                if (slen[i] == 1) begin
                    sfr[i]    = sfr[i] - 1;
                    slen[i]   = flen[i];
                    sfirst[i] = 1'b1;
                end else begin
                    slen[i] = slen[i] - 1;
                end
            end
        end
        drive();
        #1;
    endtask

    logic [1:0]  exp_g[5];
    logic [31:0] exp_d[5];

    initial begin
        for (int i = 0; i < NS; i++) begin
            sd[i] = '0; slen[i] = 1; sfr[i] = 0; flen[i] = 1; sfirst[i] = 1'b0;
        end
        rst      = 1'b1;
        m_tready = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("rst_tdata",  m_tdata, 32'd0);
        chk("rst_busy",   {31'b0, busy}, 32'd0);
        chk("rst_grant",  {30'b0, grant_id}, 32'd0);
        chk("rst_tready", {28'b0, s_tready}, 32'd0);
        rst = 1'b0;
        #1;

        // ---- single source, 4-beat frame
        start_src(0, 1, 4, 32'h12345678);
        #1;
        chk("t1_idle_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("t1_idle_tready", {28'b0, s_tready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t1_tdata",  m_tdata, 32'h12345678 + k);
            chk("t1_tvalid", {31'b0, m_tvalid}, 32'd1);
            chk("t1_tlast",  {31'b0, m_tlast}, (k == 3) ? 32'd1 : 32'd0);
            chk("t1_tuser",  {31'b0, m_tuser}, (k == 0) ? 32'd1 : 32'd0);
            chk("t1_busy",   {31'b0, busy}, 32'd1);
            chk("t1_grant",  {30'b0, grant_id}, 32'd0);
            chk("t1_tready", {28'b0, s_tready}, 32'b0001);
        end
        cyc();
        chk("t1_end_busy",   {31'b0, busy}, 32'd0);
        chk("t1_end_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("t1_end_grant",  {30'b0, grant_id}, 32'd0);
`ifdef AXIS_ARB_STATS_EN
        chk("t1_frame_cnt", {16'b0, frame_cnt}, 32'd1);
        chk("t1_beat_cnt",  {16'b0, beat_cnt}, 32'd4);
`endif

        // pulse reset so the pointer returns to source 0
        rst = 1'b1;
        #1;
        chk("rst2_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        #1;

        // ---- sources 0 and 2 each send a 2-beat frame
        start_src(0, 1, 2, 32'hA0);
        start_src(2, 1, 2, 32'hC0);
        #1;
        chk("t2_idle_busy", {31'b0, busy}, 32'd0);
        cyc();
        chk("t2_g0",      {30'b0, grant_id}, 32'd0);
        chk("t2_d0",      m_tdata, 32'hA0);
        chk("t2_rdy0",    {28'b0, s_tready}, 32'b0001);
        cyc();
        chk("t2_d1",      m_tdata, 32'hA1);
        chk("t2_last1",   {31'b0, m_tlast}, 32'd1);
        cyc();
        chk("t2_gap_busy",   {31'b0, busy}, 32'd0);
        chk("t2_gap_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("t2_gap_tready", {28'b0, s_tready}, 32'd0);
        chk("t2_gap_grant",  {30'b0, grant_id}, 32'd0);
        cyc();
        chk("t2_g2",      {30'b0, grant_id}, 32'd2);
        chk("t2_d2",      m_tdata, 32'hC0);
        chk("t2_rdy2",    {28'b0, s_tready}, 32'b0100);
        cyc();
        chk("t2_d3",      m_tdata, 32'hC1);
        cyc();
        chk("t2_end_busy",  {31'b0, busy}, 32'd0);
        chk("t2_end_grant", {30'b0, grant_id}, 32'd2);

        // ---- all four request; pointer is 3 after granting source 2
        exp_g[0] = 2'd3; exp_d[0] = 32'h4000;
        exp_g[1] = 2'd0; exp_d[1] = 32'h1000;
        exp_g[2] = 2'd1; exp_d[2] = 32'h2000;
        exp_g[3] = 2'd2; exp_d[3] = 32'h3000;
        exp_g[4] = 2'd3; exp_d[4] = 32'h4002;
        for (int i = 0; i < NS; i++) start_src(i, 2, 2, 32'h1000 * (i + 1));
        #1;
        for (int f = 0; f < 5; f++) begin
            cyc();
            chk("t3_grant", {30'b0, grant_id}, {30'b0, exp_g[f]});
            chk("t3_first", m_tdata, exp_d[f]);
            chk("t3_busy",  {31'b0, busy}, 32'd1);
            cyc();
            chk("t3_last",  {31'b0, m_tlast}, 32'd1);
            chk("t3_second", m_tdata, exp_d[f] + 1);
            cyc();
            chk("t3_gap_busy",   {31'b0, busy}, 32'd0);
            chk("t3_gap_tvalid", {31'b0, m_tvalid}, 32'd0);
        end
        kill_all();
        #1;

        // ---- granted source stalls 3 cycles; source 1 waiting (pointer 0)
        start_src(0, 1, 3, 32'h50);
        start_src(1, 1, 2, 32'h60);
        #1;
        cyc();
        chk("t4_g0", {30'b0, grant_id}, 32'd0);
        chk("t4_d0", m_tdata, 32'h50);
        cyc();
        chk("t4_d1", m_tdata, 32'h51);
        hold[0] = 1'b1;
        drive();
        #1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) cyc();
            chk("t4_stall_tvalid", {31'b0, m_tvalid}, 32'd0);
            chk("t4_stall_busy",   {31'b0, busy}, 32'd1);
            chk("t4_stall_grant",  {30'b0, grant_id}, 32'd0);
            chk("t4_stall_tready", {28'b0, s_tready}, 32'b0001);
        end
        hold[0] = 1'b0;
        cyc();
        chk("t4_resume_tvalid", {31'b0, m_tvalid}, 32'd1);
        chk("t4_resume_d",      m_tdata, 32'h51);
        cyc();
        chk("t4_d2",   m_tdata, 32'h52);
        chk("t4_last", {31'b0, m_tlast}, 32'd1);
        cyc();
        chk("t4_gap_busy", {31'b0, busy}, 32'd0);
        cyc();
        chk("t4_g1", {30'b0, grant_id}, 32'd1);
        chk("t4_d60", m_tdata, 32'h60);
        cyc();
        cyc();
        chk("t4_end_busy", {31'b0, busy}, 32'd0);

        // ---- downstream backpressure 5 cycles (pointer 2)
        start_src(2, 1, 3, 32'h70);
        out_beats = 0;
        #1;
        cyc();
        chk("t5_g2", {30'b0, grant_id}, 32'd2);
        m_tready = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) cyc();
            chk("t5_bp_tdata",  m_tdata, 32'h70);
            chk("t5_bp_tvalid", {31'b0, m_tvalid}, 32'd1);
            chk("t5_bp_tready", {28'b0, s_tready}, 32'd0);
        end
        m_tready = 1'b1;
        #1;
        chk("t5_rel_tready", {28'b0, s_tready}, 32'b0100);
        chk("t5_rel_tdata",  m_tdata, 32'h70);
        cyc();
        chk("t5_d1", m_tdata, 32'h71);
        cyc();
        chk("t5_d2", m_tdata, 32'h72);
        chk("t5_last", {31'b0, m_tlast}, 32'd1);
        cyc();
        chk("t5_end_busy", {31'b0, busy}, 32'd0);
        chk("t5_beats", out_beats, 32'd3);

        // ---- reset in the middle of a frame (pointer 3)
        start_src(3, 1, 4, 32'h80);
        #1;
        cyc();
        chk("t6_g3", {30'b0, grant_id}, 32'd3);
        cyc();
        chk("t6_d1", m_tdata, 32'h81);
        rst = 1'b1;
        #1;
        chk("t6_rst_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("t6_rst_tdata",  m_tdata, 32'd0);
        chk("t6_rst_tlast",  {31'b0, m_tlast}, 32'd0);
        chk("t6_rst_busy",   {31'b0, busy}, 32'd0);
        chk("t6_rst_grant",  {30'b0, grant_id}, 32'd0);
        chk("t6_rst_tready", {28'b0, s_tready}, 32'd0);
`ifdef AXIS_ARB_STATS_EN
        chk("t6_rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
`endif
        kill_all();
        rst = 1'b0;
        start_src(0, 1, 1, 32'h90);
        start_src(2, 1, 1, 32'hA0);
        #1;
        chk("t6_idle_busy", {31'b0, busy}, 32'd0);
        cyc();
        chk("t6_g0",    {30'b0, grant_id}, 32'd0);
        chk("t6_d90",   m_tdata, 32'h90);
        chk("t6_last",  {31'b0, m_tlast}, 32'd1);
        chk("t6_user",  {31'b0, m_tuser}, 32'd1);
        cyc();
        chk("t6_gap_busy", {31'b0, busy}, 32'd0);
        cyc();
        chk("t6_g2",  {30'b0, grant_id}, 32'd2);
        chk("t6_dA0", m_tdata, 32'hA0);
        cyc();
        chk("t6_end_busy", {31'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
